fifo_unpack: RTL and testbench
==============================

Name: fifo_unpack

Overview:
- Width-down-converting FIFO: the read-side counterpart of fifo_flush.
- Accepts 32-bit words, each tagged with a valid-nibble count, and returns them one 4-bit nibble per read.
- Sits between the packed 32-bit datapath and 4-bit consumers. A partial word produced by a packer flush is carried through intact.
- Has its own flush control that discards stored data and reports completion.

Parameters:
- DEPTH, 4: number of 32-bit word entries; must be a power of 2, at least 2.
- ADDR_W, 2: log2(DEPTH); width of the read/write pointers.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- fifo_wr_valid_i  input  1  write request for this cycle.
- fifo_wr_data_i  input  32  word to store.
- fifo_wr_cnt_i  input  3  number of valid nibbles minus 1 (0 = one nibble, 7 = full word).
- fifo_rd_valid_i  input  1  read request: consume one nibble.
- fifo_flush_i  input  1  level flush request.
- fifo_rd_data_o  output  4  current head nibble.
- fifo_last_o  output  1  current head nibble is the last valid nibble of its word.
- fifo_data_avail_o  output  1  a nibble is readable this cycle.
- fifo_flush_done_o  output  1  one-cycle pulse when a flush completes.
- fifo_empty_o  output  1  no stored words.
- fifo_full_o  output  1  DEPTH words stored.

Behaviour:
- Reset (async, active-high) clears:
  - write pointer, read pointer and occupancy count (ADDR_W+1 bits) to 0;
  - nibble index (3 bits) to 0;
  - flush FSM to IDLE.
- Output values while reset is asserted and immediately after release:
  - fifo_empty_o=1, fifo_full_o=0, fifo_data_avail_o=0, fifo_last_o=0, fifo_flush_done_o=0, fifo_rd_data_o=0.
- Storage: DEPTH entries, each 32-bit data plus 3-bit count. No reset is required on the storage array.
- Write:
  - Accepted when fifo_wr_valid_i=1, fifo_full_o=0 and the FSM is IDLE.
  - An accepted write stores data and count at the write pointer, increments the write pointer (wraps modulo DEPTH) and increments the count.
  - Writes attempted while full are silently dropped.
- Read-side outputs are combinational from registered state:
  - fifo_data_avail_o = (count != 0) and FSM == IDLE.
  - fifo_rd_data_o = head word bits [4*idx+3 : 4*idx]; it is 0 when no data is available.
  - fifo_last_o = data_avail and (idx == head count).
- Read:
  - Accepted when fifo_rd_valid_i=1 and fifo_data_avail_o=1.
  - If idx < head count: idx increments.
  - If idx == head count: idx returns to 0, the read pointer increments (wraps) and the count decrements (word pop).
  - A read while empty is ignored and produces no state change.
- Simultaneous write and pop:
  - Both occur; the count is unchanged.
  - Full is evaluated on the pre-cycle count, so a write that arrives while full is dropped even if a pop occurs in the same cycle.
- Latency: a word written in cycle N has its first nibble visible (fifo_data_avail_o=1) in cycle N+1.
- fifo_empty_o = (count == 0); fifo_full_o = (count == DEPTH).
- Flush FSM, states IDLE, FLUSH, DONE:
  - IDLE -> FLUSH when fifo_flush_i=1. At that edge the pointers, count and idx clear to 0.
  - FLUSH: holds while fifo_flush_i=1. Storage stays empty; all writes and reads are ignored.
  - FLUSH -> DONE when fifo_flush_i=0.
  - DONE: fifo_flush_done_o=1 for exactly this cycle; writes and reads are ignored. DONE -> IDLE unconditionally.
- Flush arriving mid-word: the partially read word and all queued words are discarded.
- Reset during FLUSH or DONE returns the FSM to IDLE without any fifo_flush_done_o pulse.

Optional Feature:
- Macro: FIFO_UNPACK_MSB_FIRST_EN.
- Defined: nibble idx is taken from bits [31-4*idx : 28-4*idx]. The valid nibbles are the upper (cnt+1) nibbles, delivered MSB first.
- Undefined (default): LSB-first order as described in Behaviour.
- The count semantics and all handshakes are identical in both builds.

Test Plan:
- Reset, then write 32'h87654321 with cnt=7, then hold rd_valid=1 for 8 cycles -> rd_data sequence 1,2,3,4,5,6,7,8; last=1 only on 8; empty_o=1 afterwards.
- Write 32'h000000A6 with cnt=1, then read 2 nibbles -> 6 then A; last=1 on A. With FIFO_UNPACK_MSB_FIRST_EN, write 32'hA6000000 with cnt=1 -> A then 6.
- Write 5 words back-to-back with DEPTH=4 -> full_o=1 after the 4th write; the 5th is dropped. Reading all 32 nibbles returns only words 1-4, and empty_o=1 at the end.
- With full_o=1, issue the last-nibble read and a write in the same cycle -> the pop occurs, the write is dropped, count=3.
- Store 2 words, read 3 nibbles, then hold flush_i=1 for 2 cycles with wr_valid=1 -> empty_o=1 from the first flush edge; data_avail_o=0 throughout; flush_done_o pulses for 1 cycle after flush_i falls. A subsequent write of 32'h00000003 with cnt=0 reads back as 3 with last=1.
- Assert reset during FLUSH and during a partly read word -> all outputs return to their reset values immediately, and no flush_done_o pulse occurs.

Source files
------------

// File: rtl/fifo_unpack.sv
`default_nettype none
// ============================================================================
// Module      : fifo_unpack
// Description : Width-down FIFO. Stores 32-bit words tagged with a
//               valid-nibble count and returns one 4-bit nibble per read.
//               It also has a flush controller that discards stored data.
//               Define FIFO_UNPACK_MSB_FIRST_EN to deliver nibbles MSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_unpack #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fifo_wr_valid_i,
    input  logic [31:0] fifo_wr_data_i,
    input  logic [2:0]  fifo_wr_cnt_i,
    input  logic        fifo_rd_valid_i,
    input  logic        fifo_flush_i,
    output logic [3:0]  fifo_rd_data_o,
    output logic        fifo_last_o,
    output logic        fifo_data_avail_o,
    output logic        fifo_flush_done_o,
    output logic        fifo_empty_o,
    output logic        fifo_full_o
);

    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [2:0]          idx_q, idx_d;

    logic [31:0]         mem_data [DEPTH];
    logic [2:0]          mem_cnt  [DEPTH];

    logic [31:0]         head_word;
    logic [2:0]          head_cnt;
    logic [3:0]          head_nib;
    logic                is_idle;
    logic                data_avail;
    logic                full;
    logic                head_last;
    logic                flush_start;
    logic                wr_en;
    logic                rd_en;
    logic                pop;

    assign head_word  = mem_data[rd_ptr_q];
    assign head_cnt   = mem_cnt[rd_ptr_q];
    assign is_idle    = (state_q == ST_IDLE);
    assign full       = (count_q == FULL_COUNT);
    assign data_avail = (count_q != '0) && is_idle;
    assign head_last  = (idx_q == head_cnt);

`ifdef FIFO_UNPACK_MSB_FIRST_EN
    assign head_nib = head_word[5'd31 - {idx_q, 2'b00} -: 4];
`else
    assign head_nib = head_word[{idx_q, 2'b00} +: 4];
`endif

    // A flush request in IDLE wins over any same-cycle read or write.
    assign flush_start = is_idle && fifo_flush_i;
    assign wr_en       = fifo_wr_valid_i && !full && is_idle && !fifo_flush_i;
    assign rd_en       = fifo_rd_valid_i && data_avail && !fifo_flush_i;
    assign pop         = rd_en && head_last;

    assign fifo_data_avail_o = data_avail;
    assign fifo_rd_data_o    = data_avail ? head_nib : 4'h0;
    assign fifo_last_o       = data_avail && head_last;
    assign fifo_flush_done_o = (state_q == ST_DONE);
    assign fifo_empty_o      = (count_q == '0);
    assign fifo_full_o       = full;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (fifo_flush_i) state_d = ST_FLUSH;
            ST_FLUSH: if (!fifo_flush_i) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        idx_d    = idx_q;
        if (flush_start) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            idx_d    = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_en) begin
                if (head_last) begin
                    idx_d    = '0;
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            // Write and pop together leave the occupancy unchanged.
            case ({wr_en, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
        end
    end

    // Storage carries no reset; the occupancy count guards every access.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_data[wr_ptr_q] <= fifo_wr_data_i;
            mem_cnt[wr_ptr_q]  <= fifo_wr_cnt_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_unpack.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_unpack
// Description : Scoreboard bench for fifo_unpack; directed and random traffic
//               checked against a nibble-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_unpack;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic        clk;
    logic        reset;
    logic        fifo_wr_valid_i;
    logic [31:0] fifo_wr_data_i;
    logic [2:0]  fifo_wr_cnt_i;
    logic        fifo_rd_valid_i;
    logic        fifo_flush_i;
    logic [3:0]  fifo_rd_data_o;
    logic        fifo_last_o;
    logic        fifo_data_avail_o;
    logic        fifo_flush_done_o;
    logic        fifo_empty_o;
    logic        fifo_full_o;

    fifo_unpack #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .fifo_wr_valid_i   (fifo_wr_valid_i),
        .fifo_wr_data_i    (fifo_wr_data_i),
        .fifo_wr_cnt_i     (fifo_wr_cnt_i),
        .fifo_rd_valid_i   (fifo_rd_valid_i),
        .fifo_flush_i      (fifo_flush_i),
        .fifo_rd_data_o    (fifo_rd_data_o),
        .fifo_last_o       (fifo_last_o),
        .fifo_data_avail_o (fifo_data_avail_o),
        .fifo_flush_done_o (fifo_flush_done_o),
        .fifo_empty_o      (fifo_empty_o),
        .fifo_full_o       (fifo_full_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [3:0] nib;
        logic       last;
    } nib_t;

    // Reference model: every readable nibble in delivery order, plus flush phase.
    nib_t model_q[$];
    int   model_st;    // 0 idle, 1 flushing, 2 done
    int   checks;
    int   errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int words();
        int n = 0;
        foreach (model_q[i]) if (model_q[i].last) n++;
        return n;
    endfunction

    // Monitor: compares DUT outputs with the model and consumes read nibbles.
    always @(negedge clk) begin
        logic exp_avail;
        exp_avail = (model_q.size() != 0) && (model_st == 0);
        chk("data_avail", {31'd0, fifo_data_avail_o}, {31'd0, exp_avail});
        chk("empty", {31'd0, fifo_empty_o}, {31'd0, words() == 0});
        chk("full", {31'd0, fifo_full_o}, {31'd0, words() == DEPTH});
        chk("flush_done", {31'd0, fifo_flush_done_o}, {31'd0, model_st == 2});
        if (exp_avail) begin
            chk("rd_data", {28'd0, fifo_rd_data_o}, {28'd0, model_q[0].nib});
            chk("last", {31'd0, fifo_last_o}, {31'd0, model_q[0].last});
            if (fifo_rd_valid_i && !reset) void'(model_q.pop_front());
        end else begin
            chk("rd_data_idle", {28'd0, fifo_rd_data_o}, 32'd0);
            chk("last_idle", {31'd0, fifo_last_o}, 32'd0);
        end
    end

    task automatic push_word(input logic [31:0] d, input logic [2:0] c);
        nib_t n;
        for (int k = 0; k <= int'(c); k++) begin
`ifdef FIFO_UNPACK_MSB_FIRST_EN
            n.nib = 4'((d >> (28 - 4 * k)) & 32'hF);
`else
            n.nib = 4'((d >> (4 * k)) & 32'hF);
`endif
            n.last = (k == int'(c));
            model_q.push_back(n);
        end
    endtask

    // One clock of stimulus; inputs change 2 time units after the active edge.
    task automatic cycle(input bit wr, input logic [31:0] d, input logic [2:0] c,
                         input bit rd, input bit fl);
        bit acc;
        fifo_wr_valid_i = wr;
        fifo_wr_data_i  = d;
        fifo_wr_cnt_i   = c;
        fifo_rd_valid_i = rd;
        fifo_flush_i    = fl;
        acc = wr && (model_st == 0) && !fl && (words() < DEPTH);
        @(posedge clk);
        case (model_st)
            0: if (fl) begin model_q.delete(); model_st = 1; end
            1: if (!fl) model_st = 2;
            default: model_st = 0;
        endcase
        if (acc) push_word(d, c);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        fifo_wr_valid_i = 1'b0;
        fifo_wr_data_i  = 32'd0;
        fifo_wr_cnt_i   = 3'd0;
        fifo_rd_valid_i = 1'b0;
        fifo_flush_i    = 1'b0;
        model_q.delete();
        model_st = 0;
        #1;
        chk("rst_empty", {31'd0, fifo_empty_o}, 32'd1);
        chk("rst_full", {31'd0, fifo_full_o}, 32'd0);
        chk("rst_avail", {31'd0, fifo_data_avail_o}, 32'd0);
        chk("rst_last", {31'd0, fifo_last_o}, 32'd0);
        chk("rst_done", {31'd0, fifo_flush_done_o}, 32'd0);
        chk("rst_data", {28'd0, fifo_rd_data_o}, 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit fl_r;
        checks   = 0;
        errors   = 0;
        model_st = 0;
        do_reset();

        // Full word, nibbles in order.
        cycle(1'b1, 32'h87654321, 3'd7, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'd0, 3'd0, 1'b1, 1'b0);
        idle(1);

        // Two-nibble partial word.
`ifdef FIFO_UNPACK_MSB_FIRST_EN
        cycle(1'b1, 32'hA6000000, 3'd1, 1'b0, 1'b0);
`else
        cycle(1'b1, 32'h000000A6, 3'd1, 1'b0, 1'b0);
`endif
        for (int i = 0; i < 2; i++) cycle(1'b0, 32'd0, 3'd0, 1'b1, 1'b0);
        idle(1);

        // Overfill: fifth word dropped, then drain everything.
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h11111111 * (i + 1), 3'd7, 1'b0, 1'b0);
        for (int i = 0; i < 34; i++) cycle(1'b0, 32'd0, 3'd0, 1'b1, 1'b0);

        // Full plus simultaneous pop and write: write dropped, three words remain.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h0000000A + i, 3'd0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000000F, 3'd0, 1'b1, 1'b0);
        idle(1);
        chk("words_after_pop", {31'd0, fifo_full_o}, 32'd0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 3'd0, 1'b1, 1'b0);

        // Flush mid-word with writes held high.
        cycle(1'b1, 32'hCAFEBABE, 3'd3, 1'b0, 1'b0);
        cycle(1'b1, 32'h12345678, 3'd5, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 3'd0, 1'b1, 1'b0);
        cycle(1'b1, 32'h55555555, 3'd7, 1'b0, 1'b1);
        cycle(1'b1, 32'h55555555, 3'd7, 1'b0, 1'b1);
        cycle(1'b1, 32'h55555555, 3'd7, 1'b0, 1'b0);
        idle(1);
`ifdef FIFO_UNPACK_MSB_FIRST_EN
        cycle(1'b1, 32'h30000000, 3'd0, 1'b0, 1'b0);
`else
        cycle(1'b1, 32'h00000003, 3'd0, 1'b0, 1'b0);
`endif
        cycle(1'b0, 32'd0, 3'd0, 1'b1, 1'b0);
        idle(1);

        // Reset during flush: no done pulse afterwards.
        cycle(1'b1, 32'h9ABCDEF0, 3'd7, 1'b0, 1'b0);
        cycle(1'b0, 32'd0, 3'd0, 1'b0, 1'b1);
        cycle(1'b0, 32'd0, 3'd0, 1'b0, 1'b1);
        do_reset();
        idle(2);

        // Reset during a partly read word.
        cycle(1'b1, 32'h9ABCDEF0, 3'd7, 1'b0, 1'b0);
        cycle(1'b0, 32'd0, 3'd0, 1'b1, 1'b0);
        cycle(1'b0, 32'd0, 3'd0, 1'b1, 1'b0);
        do_reset();
        idle(2);

        // Randomized traffic with occasional flushes.
        fl_r = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (fl_r) fl_r = ($urandom_range(0, 2) != 0);
            else      fl_r = ($urandom_range(0, 49) == 0);
            cycle(1'($urandom_range(0, 1)), $urandom(), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 2) != 0), fl_r);
        end
        for (int i = 0; i < 40; i++) cycle(1'b0, 32'd0, 3'd0, 1'b1, 1'b0);
        chk("final_empty", {31'd0, fifo_empty_o}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
